axi_arbiter: RTL and testbench

AXI_ARBITER -- requirements
Module: axi_arbiter

---
 rtl/axi_arbiter_pkg.sv | 22 ++
 rtl/rr_arbiter2.sv | 23 ++
 rtl/axi_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_axi_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arbiter_pkg.sv
// Shared types and constants for the two-requester AXI arbiter (IFU read, LSU read/write).
package axi_arbiter_pkg;

  localparam int ID_WIDTH = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_S0 = 2'd1,
    ST_RD_S1 = 2'd2,
    ST_WR_S1 = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester always wins; on a tie the side
// that did not own the port last time wins.
module rr_arbiter2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (req0_i && req1_i) begin
      gnt0_o = last1_i;
      gnt1_o = ~last1_i;
    end else begin
      gnt0_o = req0_i;
      gnt1_o = req1_i;
    end
  end

endmodule

// File: rtl/axi_arbiter.sv
// Arbitrates the IFU read port (S0) and the LSU read/write port (S1) onto one
// downstream AXI port; one transaction owns the port from grant to final response.
module axi_arbiter
  import axi_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n_sync,
  // S0 (IFU) read
  input  logic [ADDR_WIDTH-1:0]   s0_araddr,
  input  logic                    s0_arvalid,
  output logic                    s0_arready,
  input  logic [ID_WIDTH-1:0]     s0_arid,
  input  logic [7:0]              s0_arlen,
  input  logic [2:0]              s0_arsize,
  input  logic [1:0]              s0_arburst,
  output logic [DATA_WIDTH-1:0]   s0_rdata,
  output logic [1:0]              s0_rresp,
  output logic                    s0_rvalid,
  input  logic                    s0_rready,
  output logic [ID_WIDTH-1:0]     s0_rid,
  output logic                    s0_rlast,
  // S1 (LSU) read
  input  logic [ADDR_WIDTH-1:0]   s1_araddr,
  input  logic                    s1_arvalid,
  output logic                    s1_arready,
  input  logic [ID_WIDTH-1:0]     s1_arid,
  input  logic [7:0]              s1_arlen,
  input  logic [2:0]              s1_arsize,
  input  logic [1:0]              s1_arburst,
  output logic [DATA_WIDTH-1:0]   s1_rdata,
  output logic [1:0]              s1_rresp,
  output logic                    s1_rvalid,
  input  logic                    s1_rready,
  output logic [ID_WIDTH-1:0]     s1_rid,
  output logic                    s1_rlast,
  // S1 (LSU) write
  input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
  input  logic                    s1_awvalid,
  output logic                    s1_awready,
  input  logic [ID_WIDTH-1:0]     s1_awid,
  input  logic [7:0]              s1_awlen,
  input  logic [2:0]              s1_awsize,
  input  logic [1:0]              s1_awburst,
  input  logic [DATA_WIDTH-1:0]   s1_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
  input  logic                    s1_wvalid,
  output logic                    s1_wready,
  input  logic                    s1_wlast,
  output logic [1:0]              s1_bresp,
  output logic                    s1_bvalid,
  input  logic                    s1_bready,
  output logic [ID_WIDTH-1:0]     s1_bid,
  // Downstream master
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [ID_WIDTH-1:0]     m_arid,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  input  logic [ID_WIDTH-1:0]     m_rid,
  input  logic                    m_rlast,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [ID_WIDTH-1:0]     m_awid,
  output logic [7:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic                    m_wlast,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  input  logic [ID_WIDTH-1:0]     m_bid
);

  arb_state_e state_q, state_d;
  logic       last_s1_q, last_s1_d;
  logic       ar_done_q, ar_done_d;
  logic       aw_done_q, aw_done_d;
  logic       gnt0, gnt1;
  logic       rd_exit, wr_exit;

  rr_arbiter2 u_rr (
    .req0_i  (s0_arvalid),
    .req1_i  (s1_awvalid | s1_arvalid),
    .last1_i (last_s1_q),
    .gnt0_o  (gnt0),
    .gnt1_o  (gnt1)
  );

  assign rd_exit = m_rvalid & m_rready & m_rlast;
  assign wr_exit = m_bvalid & m_bready;

  always_ff @(posedge clk) begin
    if (!rst_n_sync) begin
      state_q   <= ST_IDLE;
      last_s1_q <= 1'b0;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_s1_q <= last_s1_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
    end
  end

  // Grant is taken from IDLE only, so every exit leaves one idle bubble.
  always_comb begin
    state_d   = state_q;
    last_s1_d = last_s1_q;
    ar_done_d = ar_done_q;
    aw_done_d = aw_done_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt0) begin
          state_d = ST_RD_S0;
        end else if (gnt1) begin
          state_d = s1_awvalid ? ST_WR_S1 : ST_RD_S1;
        end
      end
      ST_RD_S0, ST_RD_S1: begin
        if (m_arvalid && m_arready) ar_done_d = 1'b1;
        if (rd_exit) begin
          state_d   = ST_IDLE;
          ar_done_d = 1'b0;
          last_s1_d = (state_q == ST_RD_S1);
        end
      end
      ST_WR_S1: begin
        if (m_awvalid && m_awready) aw_done_d = 1'b1;
        if (wr_exit) begin
          state_d   = ST_IDLE;
          aw_done_d = 1'b0;
          last_s1_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Channel steering; payload buses stay at zero whenever their valid is low.
  always_comb begin
    s0_arready = 1'b0;  s0_rvalid = 1'b0;  s0_rdata = '0;  s0_rresp = '0;
    s0_rid     = '0;    s0_rlast  = 1'b0;
    s1_arready = 1'b0;  s1_rvalid = 1'b0;  s1_rdata = '0;  s1_rresp = '0;
    s1_rid     = '0;    s1_rlast  = 1'b0;
    s1_awready = 1'b0;  s1_wready = 1'b0;
    s1_bvalid  = 1'b0;  s1_bresp  = '0;    s1_bid   = '0;
    m_arvalid  = 1'b0;  m_araddr  = '0;    m_arid   = '0;  m_arlen  = '0;
    m_arsize   = '0;    m_arburst = '0;    m_rready = 1'b0;
    m_awvalid  = 1'b0;  m_awaddr  = '0;    m_awid   = '0;  m_awlen  = '0;
    m_awsize   = '0;    m_awburst = '0;
    m_wvalid   = 1'b0;  m_wdata   = '0;    m_wstrb  = '0;  m_wlast  = 1'b0;
    m_bready   = 1'b0;

    if (state_q == ST_RD_S0) begin
      m_arvalid  = s0_arvalid & ~ar_done_q;
      s0_arready = m_arready & ~ar_done_q;
      if (m_arvalid) begin
        m_araddr  = s0_araddr;
        m_arid    = s0_arid;
        m_arlen   = s0_arlen;
        m_arsize  = s0_arsize;
        m_arburst = s0_arburst;
      end
      m_rready  = s0_rready;
      s0_rvalid = m_rvalid;
      if (m_rvalid) begin
        s0_rdata = m_rdata;
        s0_rresp = m_rresp;
        s0_rid   = m_rid;
        s0_rlast = m_rlast;
      end
    end

    if (state_q == ST_RD_S1) begin
      m_arvalid  = s1_arvalid & ~ar_done_q;
      s1_arready = m_arready & ~ar_done_q;
      if (m_arvalid) begin
        m_araddr  = s1_araddr;
        m_arid    = s1_arid;
        m_arlen   = s1_arlen;
        m_arsize  = s1_arsize;
        m_arburst = s1_arburst;
      end
      m_rready  = s1_rready;
      s1_rvalid = m_rvalid;
      if (m_rvalid) begin
        s1_rdata = m_rdata;
        s1_rresp = m_rresp;
        s1_rid   = m_rid;
        s1_rlast = m_rlast;
      end
    end

    if (state_q == ST_WR_S1) begin
      m_awvalid  = s1_awvalid & ~aw_done_q;
      s1_awready = m_awready & ~aw_done_q;
      if (m_awvalid) begin
        m_awaddr  = s1_awaddr;
        m_awid    = s1_awid;
        m_awlen   = s1_awlen;
        m_awsize  = s1_awsize;
        m_awburst = s1_awburst;
      end
      m_wvalid  = s1_wvalid;
      s1_wready = m_wready;
      if (m_wvalid) begin
        m_wdata = s1_wdata;
        m_wstrb = s1_wstrb;
        m_wlast = s1_wlast;
      end
      m_bready  = s1_bready;
      s1_bvalid = m_bvalid;
      if (m_bvalid) begin
        s1_bresp = m_bresp;
        s1_bid   = m_bid;
      end
    end
  end

endmodule

// File: tb/tb_axi_arbiter.sv
// Scoreboard bench for axi_arbiter: the bench plays both upstream masters and the
// downstream slave, and queues the read beats each upstream master should receive.
module tb_axi_arbiter;
  import axi_arbiter_pkg::*;

  logic        clk;
  logic        rst_n_sync;
  logic [31:0] s0_araddr;  logic s0_arvalid; logic s0_arready; logic [3:0] s0_arid;
  logic [7:0]  s0_arlen;   logic [2:0] s0_arsize; logic [1:0] s0_arburst;
  logic [31:0] s0_rdata;   logic [1:0] s0_rresp;  logic s0_rvalid; logic s0_rready;
  logic [3:0]  s0_rid;     logic s0_rlast;
  logic [31:0] s1_araddr;  logic s1_arvalid; logic s1_arready; logic [3:0] s1_arid;
  logic [7:0]  s1_arlen;   logic [2:0] s1_arsize; logic [1:0] s1_arburst;
  logic [31:0] s1_rdata;   logic [1:0] s1_rresp;  logic s1_rvalid; logic s1_rready;
  logic [3:0]  s1_rid;     logic s1_rlast;
  logic [31:0] s1_awaddr;  logic s1_awvalid; logic s1_awready; logic [3:0] s1_awid;
  logic [7:0]  s1_awlen;   logic [2:0] s1_awsize; logic [1:0] s1_awburst;
  logic [31:0] s1_wdata;   logic [3:0] s1_wstrb;  logic s1_wvalid; logic s1_wready;
  logic        s1_wlast;
  logic [1:0]  s1_bresp;   logic s1_bvalid; logic s1_bready; logic [3:0] s1_bid;
  logic [31:0] m_araddr;   logic m_arvalid; logic m_arready; logic [3:0] m_arid;
  logic [7:0]  m_arlen;    logic [2:0] m_arsize; logic [1:0] m_arburst;
  logic [31:0] m_rdata;    logic [1:0] m_rresp;  logic m_rvalid; logic m_rready;
  logic [3:0]  m_rid;      logic m_rlast;
  logic [31:0] m_awaddr;   logic m_awvalid; logic m_awready; logic [3:0] m_awid;
  logic [7:0]  m_awlen;    logic [2:0] m_awsize; logic [1:0] m_awburst;
  logic [31:0] m_wdata;    logic [3:0] m_wstrb;  logic m_wvalid; logic m_wready;
  logic        m_wlast;
  logic [1:0]  m_bresp;    logic m_bvalid; logic m_bready; logic [3:0] m_bid;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic [3:0]  id;
    logic        last;
  } rbeat_t;

  rbeat_t exp_q[$];
  int     n_checks = 0;
  int     n_pass   = 0;
  int     ar_hs    = 0;

  axi_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n_sync(rst_n_sync),
    .s0_araddr(s0_araddr), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_arid(s0_arid),
    .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_arburst(s0_arburst),
    .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s0_rid(s0_rid), .s0_rlast(s0_rlast),
    .s1_araddr(s1_araddr), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_arid(s1_arid),
    .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_arburst(s1_arburst),
    .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .s1_rid(s1_rid), .s1_rlast(s1_rlast),
    .s1_awaddr(s1_awaddr), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready), .s1_awid(s1_awid),
    .s1_awlen(s1_awlen), .s1_awsize(s1_awsize), .s1_awburst(s1_awburst),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
    .s1_wlast(s1_wlast),
    .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready), .s1_bid(s1_bid),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rid(m_rid), .m_rlast(m_rlast),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_wlast(m_wlast),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts downstream AR handshakes so a duplicated address issue is visible.
  always @(posedge clk) begin
    if (rst_n_sync && m_arvalid && m_arready) ar_hs++;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s0_araddr = '0; s0_arvalid = 0; s0_arid = '0; s0_arlen = '0; s0_arsize = '0; s0_arburst = '0;
    s0_rready = 0;
    s1_araddr = '0; s1_arvalid = 0; s1_arid = '0; s1_arlen = '0; s1_arsize = '0; s1_arburst = '0;
    s1_rready = 0;
    s1_awaddr = '0; s1_awvalid = 0; s1_awid = '0; s1_awlen = '0; s1_awsize = '0; s1_awburst = '0;
    s1_wdata = '0; s1_wstrb = '0; s1_wvalid = 0; s1_wlast = 0; s1_bready = 0;
    m_arready = 0; m_rdata = '0; m_rresp = '0; m_rvalid = 0; m_rid = '0; m_rlast = 0;
    m_awready = 0; m_wready = 0; m_bresp = '0; m_bvalid = 0; m_bid = '0;
  endtask

  task automatic do_reset();
    rst_n_sync = 1'b0;
    idle_inputs();
    cycle();
    cycle();
    rst_n_sync = 1'b1;
  endtask

  // Drives one read from the granted state to the IDLE cycle after RLAST.
  task automatic run_read_burst(input string tag, input bit port, input logic [31:0] addr,
                                input logic [7:0] len, input logic [3:0] id,
                                input logic [1:0] resp, input int rdelay);
    logic        obs_arready, obs_rvalid, oth_rvalid, obs_rlast;
    logic [31:0] obs_rdata;
    logic [1:0]  obs_rresp;
    logic [3:0]  obs_rid;
    rbeat_t      b;
    m_arready = 1'b1;
    s0_rready = 1'b1;
    s1_rready = 1'b1;
    #1;
    obs_arready = port ? s1_arready : s0_arready;
    n_checks++;
    if (m_arvalid !== 1'b1 || obs_arready !== 1'b1)
      $display("[TB] FAIL %s ar_grant: arvalid/arready got %b/%b expected 1/1", tag, m_arvalid, obs_arready);
    else n_pass++;
    n_checks++;
    if ({m_araddr, m_arid, m_arlen} !== {addr, id, len})
      $display("[TB] FAIL %s ar_fields: got %h/%h/%h expected %h/%h/%h", tag, m_araddr, m_arid, m_arlen, addr, id, len);
    else n_pass++;
    cycle();
    for (int d = 0; d < rdelay; d++) begin
      n_checks++;
      if (m_arvalid !== 1'b0)
        $display("[TB] FAIL %s ar_after_hs: m_arvalid got %b expected 0", tag, m_arvalid);
      else n_pass++;
      cycle();
    end
    if (port) s1_arvalid = 1'b0; else s0_arvalid = 1'b0;
    m_arready = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      m_rvalid = 1'b1;
      m_rdata  = (addr ^ 32'hA5A5_0000) + 32'(i) * 32'h0101_0101;
      m_rresp  = resp;
      m_rid    = id;
      m_rlast  = (i == int'(len));
      exp_q.push_back('{data: m_rdata, resp: resp, id: id, last: (i == int'(len))});
      #1;
      obs_rvalid = port ? s1_rvalid : s0_rvalid;
      oth_rvalid = port ? s0_rvalid : s1_rvalid;
      obs_rdata  = port ? s1_rdata : s0_rdata;
      obs_rresp  = port ? s1_rresp : s0_rresp;
      obs_rid    = port ? s1_rid : s0_rid;
      obs_rlast  = port ? s1_rlast : s0_rlast;
      n_checks++;
      if (obs_rvalid !== 1'b1 || oth_rvalid !== 1'b0)
        $display("[TB] FAIL %s r_route beat %0d: own/other rvalid got %b/%b expected 1/0", tag, i, obs_rvalid, oth_rvalid);
      else n_pass++;
      if (obs_rvalid === 1'b1 && exp_q.size() > 0) begin
        b = exp_q.pop_front();
        n_checks++;
        if ({obs_rdata, obs_rresp, obs_rid, obs_rlast} !== {b.data, b.resp, b.id, b.last})
          $display("[TB] FAIL %s r_beat %0d: got %h/%b/%h/%b expected %h/%b/%h/%b", tag, i,
                   obs_rdata, obs_rresp, obs_rid, obs_rlast, b.data, b.resp, b.id, b.last);
        else n_pass++;
      end
      cycle();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    #1;
    n_checks++;
    if (m_rready !== 1'b0)
      $display("[TB] FAIL %s idle_after_rlast: m_rready got %b expected 0", tag, m_rready);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n_sync = 1'b0;
    idle_inputs();
    s0_arvalid = 1'b1;
    s1_awvalid = 1'b1;
    m_rvalid   = 1'b1;
    m_bvalid   = 1'b1;
    cycle();
    cycle();
    n_checks++;
    if ({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, s0_arready, s0_rvalid,
         s1_arready, s1_rvalid, s1_awready, s1_wready, s1_bvalid} !== 12'b0)
      $display("[TB] FAIL reset_handshakes: got %b expected 0", {m_arvalid, m_awvalid, m_wvalid, m_rready,
               m_bready, s0_arready, s0_rvalid, s1_arready, s1_rvalid, s1_awready, s1_wready, s1_bvalid});
    else n_pass++;
    n_checks++;
    if ({m_araddr, m_awaddr} !== 64'b0)
      $display("[TB] FAIL reset_buses: got %h expected 0", {m_araddr, m_awaddr});
    else n_pass++;
    idle_inputs();
    rst_n_sync = 1'b1;
  endtask

  task automatic test_ifu_read();
    do_reset();
    cycle();
    s0_araddr = 32'h3000_0000; s0_arvalid = 1'b1; s0_arid = 4'h5; s0_arlen = 8'd3;
    s0_arsize = 3'd2; s0_arburst = BURST_INCR;
    #1;
    n_checks++;
    if (m_arvalid !== 1'b0)
      $display("[TB] FAIL ifu_registered_grant: m_arvalid got %b expected 0", m_arvalid);
    else n_pass++;
    cycle();
    run_read_burst("ifu", 1'b0, 32'h3000_0000, 8'd3, 4'h5, RESP_OKAY, 0);
  endtask

  task automatic test_round_robin();
    do_reset();
    s0_araddr = 32'h3000_0100; s0_arvalid = 1'b1; s0_arid = 4'h1; s0_arlen = 8'd0;
    s1_araddr = 32'h6000_0000; s1_arvalid = 1'b1; s1_arid = 4'h9; s1_arlen = 8'd1;
    cycle();
    run_read_burst("rr_s1", 1'b1, 32'h6000_0000, 8'd1, 4'h9, RESP_OKAY, 0);
    n_checks++;
    if (m_arvalid !== 1'b0)
      $display("[TB] FAIL rr_bubble: m_arvalid got %b expected 0", m_arvalid);
    else n_pass++;
    cycle();
    run_read_burst("rr_s0", 1'b0, 32'h3000_0100, 8'd0, 4'h1, RESP_OKAY, 0);
  endtask

  task automatic test_write();
    do_reset();
    s0_araddr  = 32'h3000_1000; s0_arvalid = 1'b1; s0_arid = 4'h2; s0_arlen = 8'd0;
    s1_araddr  = 32'h5000_0000; s1_arvalid = 1'b1; s1_arid = 4'h7; s1_arlen = 8'd0;
    s1_awaddr  = 32'h4000_0010; s1_awvalid = 1'b1; s1_awid = 4'h3; s1_awlen = 8'd0;
    s1_awsize  = 3'd2; s1_awburst = BURST_INCR;
    cycle();
    m_awready = 1'b1;
    #1;
    n_checks++;
    if ({m_awvalid, s1_awready, m_arvalid} !== 3'b110 || {m_awaddr, m_awid} !== {32'h4000_0010, 4'h3})
      $display("[TB] FAIL wr_aw: got %b %h/%h expected 110 40000010/3", {m_awvalid, s1_awready, m_arvalid}, m_awaddr, m_awid);
    else n_pass++;
    cycle();
    m_awready = 1'b0;
    s1_wdata = 32'hDEAD_BEEF; s1_wstrb = 4'hF; s1_wvalid = 1'b1; s1_wlast = 1'b1;
    m_wready = 1'b1;
    #1;
    n_checks++;
    if (m_awvalid !== 1'b0)
      $display("[TB] FAIL wr_aw_once: m_awvalid got %b expected 0", m_awvalid);
    else n_pass++;
    n_checks++;
    if ({m_wvalid, s1_wready, m_wlast, m_wstrb, m_wdata} !== {3'b111, 4'hF, 32'hDEAD_BEEF})
      $display("[TB] FAIL wr_w: got %b/%h/%h expected 111/f/deadbeef", {m_wvalid, s1_wready, m_wlast}, m_wstrb, m_wdata);
    else n_pass++;
    cycle();
    s1_awvalid = 1'b0; s1_wvalid = 1'b0; s1_wlast = 1'b0; m_wready = 1'b0;
    m_bvalid = 1'b1; m_bresp = RESP_OKAY; m_bid = 4'h3; s1_bready = 1'b1;
    #1;
    n_checks++;
    if ({s1_bvalid, m_bready, s1_bresp, s1_bid} !== {2'b11, RESP_OKAY, 4'h3})
      $display("[TB] FAIL wr_b: got %b/%b/%h expected 11/00/3", {s1_bvalid, m_bready}, s1_bresp, s1_bid);
    else n_pass++;
    cycle();
    m_bvalid = 1'b0; s1_bready = 1'b0;
    #1;
    n_checks++;
    if ({m_arvalid, m_awvalid} !== 2'b00)
      $display("[TB] FAIL wr_bubble: arvalid/awvalid got %b expected 00", {m_arvalid, m_awvalid});
    else n_pass++;
    cycle();
    run_read_burst("wr_then_s0", 1'b0, 32'h3000_1000, 8'd0, 4'h2, RESP_OKAY, 0);
    cycle();
    run_read_burst("wr_then_s1rd", 1'b1, 32'h5000_0000, 8'd0, 4'h7, RESP_OKAY, 0);
  endtask

  task automatic test_ar_once();
    int hs_before;
    do_reset();
    s0_araddr = 32'h3000_2000; s0_arvalid = 1'b1; s0_arid = 4'hA; s0_arlen = 8'd1;
    cycle();
    hs_before = ar_hs;
    run_read_burst("ar_once", 1'b0, 32'h3000_2000, 8'd1, 4'hA, RESP_OKAY, 5);
    n_checks++;
    if (ar_hs - hs_before !== 1)
      $display("[TB] FAIL ar_once_count: handshakes got %0d expected 1", ar_hs - hs_before);
    else n_pass++;
  endtask

  task automatic test_reset_midburst();
    rbeat_t b;
    do_reset();
    s0_araddr = 32'h3000_3000; s0_arvalid = 1'b1; s0_arid = 4'h4; s0_arlen = 8'd3;
    s0_rready = 1'b1;
    cycle();
    m_arready = 1'b1;
    cycle();
    s0_arvalid = 1'b0; m_arready = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h1111_0000; m_rresp = RESP_OKAY; m_rid = 4'h4; m_rlast = 1'b0;
    exp_q.push_back('{data: 32'h1111_0000, resp: RESP_OKAY, id: 4'h4, last: 1'b0});
    #1;
    if (s0_rvalid === 1'b1 && exp_q.size() > 0) begin
      b = exp_q.pop_front();
      n_checks++;
      if ({s0_rdata, s0_rid, s0_rlast} !== {b.data, b.id, b.last})
        $display("[TB] FAIL midrst_beat0: got %h/%h/%b expected %h/%h/%b", s0_rdata, s0_rid, s0_rlast, b.data, b.id, b.last);
      else n_pass++;
    end
    cycle();
    m_rdata = 32'h1111_0001;
    rst_n_sync = 1'b0;
    cycle();
    rst_n_sync = 1'b1;
    #1;
    n_checks++;
    if ({s0_rvalid, m_rready, m_arvalid, m_awvalid, m_wvalid, s1_rvalid, s1_bvalid} !== 7'b0)
      $display("[TB] FAIL midrst_idle: valids got %b expected 0",
               {s0_rvalid, m_rready, m_arvalid, m_awvalid, m_wvalid, s1_rvalid, s1_bvalid});
    else n_pass++;
    m_rvalid = 1'b0;
    exp_q.delete();
    s0_araddr = 32'h3000_4000; s0_arvalid = 1'b1; s0_arlen = 8'd0;
    s1_araddr = 32'h6000_4000; s1_arvalid = 1'b1; s1_arlen = 8'd0;
    cycle();
    #1;
    n_checks++;
    if ({m_arvalid, m_araddr} !== {1'b1, 32'h6000_4000})
      $display("[TB] FAIL midrst_last_s1: arvalid/araddr got %b/%h expected 1/60004000", m_arvalid, m_araddr);
    else n_pass++;
  endtask

  task automatic test_error_resp();
    do_reset();
    s0_araddr = 32'h3000_5000; s0_arvalid = 1'b1; s0_arid = 4'hC; s0_arlen = 8'd1;
    cycle();
    run_read_burst("slverr", 1'b0, 32'h3000_5000, 8'd1, 4'hC, RESP_SLVERR, 0);
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_round_robin();
    test_write();
    test_ar_once();
    test_reset_midburst();
    test_error_resp();
    n_checks++;
    if (exp_q.size() !== 0)
      $display("[TB] FAIL scoreboard_drain: pending beats got %0d expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
